// File: rtl/uart_mem_bridge.sv
// Byte-stream to word-memory bridge between uart_rx and uart_tx: packs received
// bytes into words, fills a buffer, then replays it byte by byte on command.
module uart_mem_bridge #(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned BIG_ENDIAN = 0,
  parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    rx_dv,
  input  logic [7:0]              rx_byte,
  input  logic                    mem2uart,
  input  logic                    tx_done,
  output logic                    tx_dv,
  output logic [7:0]              tx_byte,
  output logic                    recv_done,
  output logic                    send_done,
  output logic                    overrun,
  input  logic [ADDR_W-1:0]       dbg_addr,
  output logic [8*WORD_BYTES-1:0] dbg_data
);

  localparam int unsigned W    = 8 * WORD_BYTES;
  localparam int unsigned BC_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {RECV, FULL, LOAD, FETCH, EMIT, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [W-1:0]      mem [DEPTH];
  logic [W-1:0]      asm_word, asm_merged, rd_word, word_reg;
  logic [BC_W-1:0]   byte_cnt, byte_idx;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              mem_we, last_rx, last_tx_byte, last_tx_word;

  // Logical byte position k maps to a physical lane; same mapping on receive and send.
  function automatic int unsigned phys_lane(input logic [BC_W-1:0] k);
    return (BIG_ENDIAN != 0) ? (WORD_BYTES - 1 - 32'(k)) : 32'(k);
  endfunction

  function automatic logic [7:0] get_lane(input logic [W-1:0] w, input logic [BC_W-1:0] k);
    return w[8*phys_lane(k) +: 8];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RECV;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    mem_we       = 1'b0;
    last_rx      = (byte_cnt == LAST_BYTE);
    last_tx_byte = (byte_idx == LAST_BYTE);
    last_tx_word = (rd_addr == LAST_ADDR);
    asm_merged   = asm_word;
    asm_merged[8*phys_lane(byte_cnt) +: 8] = rx_byte;
    if (clear) begin
      state_nxt = RECV;
    end else begin
      case (state)
        RECV: if (rx_dv && last_rx) begin
          mem_we = 1'b1;
          if (wr_addr == LAST_ADDR) state_nxt = FULL;
        end
        FULL:  if (mem2uart) state_nxt = LOAD;
        LOAD:  state_nxt = FETCH;
        FETCH: state_nxt = EMIT;
        EMIT:  state_nxt = WAIT;
        WAIT:  if (tx_done) begin
          if (!last_tx_byte)      state_nxt = EMIT;
          else if (!last_tx_word) state_nxt = LOAD;
          else                    state_nxt = DONE;
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = RECV;
      endcase
    end
  end

  // Buffer storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we)        mem[wr_addr] <= asm_merged;
    if (state == LOAD) rd_word <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_dv     <= 1'b0;
      tx_byte   <= '0;
      recv_done <= 1'b0;
      send_done <= 1'b0;
      overrun   <= 1'b0;
      dbg_data  <= '0;
      asm_word  <= '0;
      word_reg  <= '0;
      byte_cnt  <= '0;
      byte_idx  <= '0;
      wr_addr   <= '0;
      rd_addr   <= '0;
    end else begin
      dbg_data <= mem[dbg_addr];
      tx_dv    <= (state_nxt == EMIT);
      if (clear) begin
        recv_done <= 1'b0;
        send_done <= 1'b0;
        overrun   <= 1'b0;
        byte_cnt  <= '0;
        byte_idx  <= '0;
        wr_addr   <= '0;
        rd_addr   <= '0;
      end else begin
        if (rx_dv && state != RECV) overrun <= 1'b1;
        case (state)
          RECV: if (rx_dv) begin
            asm_word <= asm_merged;
            byte_cnt <= last_rx ? '0 : byte_cnt + BC_W'(1);
            if (last_rx) begin
              wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_W'(1);
              if (wr_addr == LAST_ADDR) recv_done <= 1'b1;
            end
          end
          FULL: if (mem2uart) rd_addr <= '0;
          FETCH: begin
            word_reg <= rd_word;
            byte_idx <= '0;
            tx_byte  <= get_lane(rd_word, '0);
          end
          WAIT: if (tx_done) begin
            if (!last_tx_byte) begin
              byte_idx <= byte_idx + BC_W'(1);
              tx_byte  <= get_lane(word_reg, byte_idx + BC_W'(1));
            end else if (!last_tx_word) begin
              rd_addr <= rd_addr + ADDR_W'(1);
            end else begin
              send_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
